// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin registered mux and its arbiter.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2 for index widths; a single channel still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter: rotating search from ptr, one-hot and index grants.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int RR       = MODE_RR,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic             found;

  // Search starts at ptr in RR mode and at 0 in fixed mode, wrapping at CHANNELS.
  always_comb begin
    int k;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      k = ((RR == MODE_RR) ? int'(ptr) : 0) + i;
      if (k >= CHANNELS) k = k - CHANNELS;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant_idx = SEL_W'(k);
      end
    end
    if (found) grant = CHANNELS'(1) << grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (RR == MODE_RR)) begin
      ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel arbitrating mux with a single registered output slot and valid/ready on every port.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int RR       = MODE_RR,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  // Handshake: a word moves on any port when valid & ready are both high at a rising edge;
  // the output slot can take a new word when empty or when its word is drained this cycle.
  logic                can_load;
  logic                load;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    sel_data;

  assign can_load = ~out_valid | out_ready;
  assign load     = can_load & (|in_valid) & ~rst;
  assign in_ready = grant & {CHANNELS{can_load & ~rst}};

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR       (RR)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant[k]) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: RR rotation, backpressure, fixed priority, 6-channel wrap, reset.
module tb_mux_rr_reg;

  logic clk;
  logic rst;

  // Instance A: 8 channels, round-robin
  logic [7:0]  valid_a, ready_a, data_a_w;
  logic [63:0] data_a;
  logic        ov_a, ordy_a;
  logic [7:0]  od_a;
  logic [2:0]  os_a;

  // Instance B: 8 channels, fixed priority
  logic [7:0]  valid_b, ready_b;
  logic [63:0] data_b;
  logic        ov_b, ordy_b;
  logic [7:0]  od_b;
  logic [2:0]  os_b;

  // Instance C: 6 channels, round-robin
  logic [5:0]  valid_c, ready_c;
  logic [47:0] data_c;
  logic        ov_c, ordy_c;
  logic [7:0]  od_c;
  logic [2:0]  os_c;

  int n_checks;
  int n_pass;
  logic [7:0] exp_q[$];

  mux_rr_reg #(.WIDTH(8), .CHANNELS(8), .RR(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
    .out_valid(ov_a), .out_data(od_a), .out_sel(os_a), .out_ready(ordy_a)
  );

  mux_rr_reg #(.WIDTH(8), .CHANNELS(8), .RR(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
    .out_valid(ov_b), .out_data(od_b), .out_sel(os_b), .out_ready(ordy_b)
  );

  mux_rr_reg #(.WIDTH(8), .CHANNELS(6), .RR(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(valid_c), .in_data(data_c), .in_ready(ready_c),
    .out_valid(ov_c), .out_data(od_c), .out_sel(os_c), .out_ready(ordy_c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [7:0] d, input logic [2:0] s);
    check({tag, ".valid"}, 32'(ov_a), 32'(v));
    check({tag, ".data"},  32'(od_a), 32'(d));
    check({tag, ".sel"},   32'(os_a), 32'(s));
  endtask

  initial begin
    logic [7:0] e;
    n_checks = 0;
    n_pass   = 0;
    data_a_w = '0;
    rst = 1'b1;
    valid_a = 8'hFF; ordy_a = 1'b1;
    valid_b = '0;    ordy_b = 1'b1;
    valid_c = '0;    ordy_c = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_a[k*8 +: 8] = 8'(k + 1);
      data_b[k*8 +: 8] = 8'(8'h10 + k);
    end
    for (int k = 0; k < 6; k++) data_c[k*8 +: 8] = 8'(8'h20 + k);

    // Reset held for two cycles with every channel requesting
    step();
    step();
    check_a("reset", 1'b0, 8'h00, 3'd0);
    check("reset.in_ready", 32'(ready_a), 32'h0);

    // Round-robin rotation: 0..7 then 0 again
    rst = 1'b0;
    #1;
    check("rr.in_ready0", 32'(ready_a), 32'h01);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'((i % 8) + 1));
    for (int i = 0; i < 9; i++) begin
      step();
      e = exp_q.pop_front();
      check_a($sformatf("rr%0d", i), 1'b1, e, 3'(i % 8));
    end
    check("rr.ptr", 32'(dut_a.u_arb.ptr), 32'd1);

    // Backpressure: slot holds word from ch0, no grants, ptr frozen
    ordy_a = 1'b0;
    #1;
    check("bp.in_ready", 32'(ready_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_a($sformatf("bp%0d", i), 1'b1, 8'd1, 3'd0);
      check($sformatf("bp%0d.ptr", i), 32'(dut_a.u_arb.ptr), 32'd1);
      check($sformatf("bp%0d.in_ready", i), 32'(ready_a), 32'h0);
    end
    ordy_a = 1'b1;
    #1;
    check("bp.release_ready", 32'(ready_a), 32'h02);
    step();
    check_a("bp.next1", 1'b1, 8'd2, 3'd1);
    step();
    check_a("bp.next2", 1'b1, 8'd3, 3'd2);

    // Drain with no requests: valid drops, data/sel hold
    valid_a = '0;
    step();
    check_a("drain", 1'b0, 8'd3, 3'd2);
    check("drain.ptr", 32'(dut_a.u_arb.ptr), 32'd3);

    // Mid-stream reset: load ch5 (search from ptr 3), stall, then reset
    valid_a = 8'b0010_0100;
    ordy_a  = 1'b0;
    step();
    check_a("pre_rst", 1'b1, 8'd6, 3'd5);
    check("pre_rst.ptr", 32'(dut_a.u_arb.ptr), 32'd6);
    rst = 1'b1;
    step();
    check("mid_rst.valid", 32'(ov_a), 32'd0);
    check("mid_rst.ptr", 32'(dut_a.u_arb.ptr), 32'd0);
    check("mid_rst.in_ready", 32'(ready_a), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(ready_a), 32'h04);
    ordy_a = 1'b1;
    step();
    check_a("post_rst.first", 1'b1, 8'd3, 3'd2);
    valid_a = '0;

    // Fixed priority: ch2 wins repeatedly over ch5
    valid_b = 8'b0010_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fix%0d.sel", i), 32'(os_b), 32'd2);
      check($sformatf("fix%0d.data", i), 32'(od_b), 32'h12);
    end
    valid_b = 8'b0010_0000;
    #1;
    check("fix.in_ready5", 32'(ready_b), 32'h20);
    step();
    check("fix.sel5", 32'(os_b), 32'd5);
    check("fix.data5", 32'(od_b), 32'h15);
    check("fix.ptr", 32'(dut_b.u_arb.ptr), 32'd0);
    valid_b = '0;

    // Six channels, only 0 and 5 requesting: alternate, wrap ptr 5 -> 0
    valid_c = 6'b10_0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("wrap%0d.sel", i), 32'(os_c), (i % 2 == 0) ? 32'd0 : 32'd5);
      check($sformatf("wrap%0d.data", i), 32'(od_c), (i % 2 == 0) ? 32'h20 : 32'h25);
      check($sformatf("wrap%0d.ptr", i), 32'(dut_c.u_arb.ptr), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    valid_c = '0;
    step();
    check("wrap.drain", 32'(ov_c), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
